// File: rtl/player_status_pkg.sv
// Shared FSM state encoding, 7-segment glyph constants and digit-to-glyph lookup
// for the player status display.
package player_status_pkg;

  typedef enum logic [1:0] {
    StTurn = 2'd0,
    StWin  = 2'd1,
    StDraw = 2'd2
  } state_e;

  // Active-low segments, bit0 = a ... bit6 = g
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;
  localparam logic [6:0] GLYPH_DASH  = 7'h3F;
  localparam logic [6:0] GLYPH_P     = 7'h0C;

  // Digits outside 1..9 have no glyph and fall back to the out-of-range dash.
  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    case (d)
      4'd1:    digit_glyph = 7'h79;
      4'd2:    digit_glyph = 7'h24;
      4'd3:    digit_glyph = 7'h30;
      4'd4:    digit_glyph = 7'h19;
      4'd5:    digit_glyph = 7'h12;
      4'd6:    digit_glyph = 7'h02;
      4'd7:    digit_glyph = 7'h78;
      4'd8:    digit_glyph = 7'h00;
      4'd9:    digit_glyph = 7'h10;
      default: digit_glyph = GLYPH_DASH;
    endcase
  endfunction

endpackage

// File: rtl/blink_timer.sv
// Half-period counter and ON/OFF phase for the win-display blink.
// phase presents the value the phase register takes at the coming edge.
module blink_timer #(
  parameter int unsigned BLINK_HALF = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic phase
);

  localparam int unsigned CW = $clog2(BLINK_HALF);
  localparam logic [CW-1:0] LAST = CW'(BLINK_HALF - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    cnt_d   = '0;
    phase_d = phase_q;
    if (clear) begin
      phase_d = 1'b1;
    end else if (enable) begin
      if (cnt_q == LAST) begin
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // Lookahead keeps the registered display aligned with the phase register.
  assign phase = reset ? 1'b1 : phase_d;

endmodule

// File: rtl/player_status_display.sv
// Turn / win / draw status on 7-segment digits. Define PLAYER_STATUS_BLINK_EN
// to blink the win display; otherwise it is steady and no blink timer exists.
module player_status_display
  import player_status_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned NUM_HEX     = 2,
  parameter int unsigned BLINK_HALF  = 25_000_000,
  localparam int unsigned PW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      win,
  input  logic                      draw,
  input  logic                      new_game,
  input  logic [PW-1:0]             curPlayer,
  output logic [NUM_HEX-1:0][6:0]   HEX,
  output logic [1:0]                state_o
);

  if (NUM_PLAYERS < 2 || NUM_PLAYERS > 9) begin : g_bad_players
    $error("NUM_PLAYERS must be 2..9");
  end
  if (NUM_HEX < 2 || NUM_HEX > 6) begin : g_bad_hex
    $error("NUM_HEX must be 2..6");
  end
  if (BLINK_HALF < 2) begin : g_bad_blink
    $error("BLINK_HALF must be at least 2");
  end

  state_e                   state_q, state_d;
  logic [3:0]               winner_q, winner_d;
  logic [NUM_HEX-1:0][6:0]  hex_d;
  logic                     blink_on;
  logic                     in_range;

  assign in_range = 32'(curPlayer) < NUM_PLAYERS;

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    unique case (state_q)
      StTurn: begin
        if (win) begin
          state_d  = StWin;
          winner_d = in_range ? 4'(curPlayer) + 4'd1 : 4'd0;
        end else if (draw) begin
          state_d = StDraw;
        end
      end
      StWin, StDraw: begin
        if (new_game) state_d = StTurn;
      end
      default: state_d = StTurn;
    endcase
  end

`ifdef PLAYER_STATUS_BLINK_EN
  blink_timer #(
    .BLINK_HALF(BLINK_HALF)
  ) u_blink_timer (
    .clk   (clk),
    .reset (reset),
    .clear (state_q == StTurn && win),
    .enable(state_q == StWin),
    .phase (blink_on)
  );
`else
  assign blink_on = 1'b1;
`endif

  // Display is decoded from the next state so HEX lags inputs by exactly one edge.
  always_comb begin
    hex_d = {NUM_HEX{GLYPH_BLANK}};
    unique case (state_d)
      StTurn: begin
        hex_d[0] = in_range ? digit_glyph(4'(curPlayer) + 4'd1) : GLYPH_DASH;
        hex_d[1] = GLYPH_P;
      end
      StWin: begin
        if (blink_on) begin
          hex_d[0] = digit_glyph(winner_d);
          hex_d[1] = GLYPH_P;
        end
      end
      StDraw: hex_d = {NUM_HEX{GLYPH_DASH}};
      default: hex_d = {NUM_HEX{GLYPH_BLANK}};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StTurn;
      winner_q <= 4'd0;
      HEX      <= {NUM_HEX{GLYPH_BLANK}};
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      HEX      <= hex_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: doc/player_status_display.md
PLAYER_STATUS_DISPLAY -- requirements
Module: player_status_display

Interface
REQ-001 Parameter NUM_PLAYERS, default 2: number of players; legal range 2..9.
REQ-002 Parameter NUM_HEX, default 2: number of driven 7-segment digits; legal range 2..6.
REQ-003 Parameter BLINK_HALF, default 25_000_000: clk cycles per blink half-period; minimum 2.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 win  input  1  one-cycle pulse: the current player has won.
REQ-007 draw  input  1  one-cycle pulse: the board is full with no winner.
REQ-008 new_game  input  1  one-cycle pulse: return to turn display.
REQ-009 curPlayer  input  PW  zero-based current player index; PW = max(1, clog2(NUM_PLAYERS)).
REQ-010 HEX  output  NUM_HEX x 7  registered, active-low segments per digit; bit0 = a ... bit6 = g.
REQ-011 state_o  output  2  current FSM state encoding, for debug and the bench.

Function
REQ-012 The FSM SHALL have three states: TURN=0, WIN=1, DRAW=2.
REQ-013 TURN SHALL go to WIN on win; else to DRAW on draw; win has priority when both are asserted.
REQ-014 On entry to WIN, the block SHALL latch winner = curPlayer + 1 in the same cycle as the win pulse.
REQ-015 WIN and DRAW SHALL be sticky; win and draw are ignored until new_game or reset.
REQ-016 new_game in WIN or DRAW SHALL go to TURN; new_game in TURN SHALL have no effect; reset overrides new_game.
REQ-017 TURN display: HEX[0] = glyph of curPlayer+1; HEX[1] = 'P'; HEX[2..NUM_HEX-1] = blank.
REQ-018 WIN display: HEX[0] = glyph of latched winner; HEX[1] = 'P'; higher digits blank; blink gated per REQ-024.
REQ-019 DRAW display: every digit SHALL show '-'.
REQ-020 If curPlayer >= NUM_PLAYERS in TURN, HEX[0] SHALL show '-' (out-of-range indicator).
REQ-021 HEX SHALL be registered, with exactly one cycle of latency from an input or state change to the output.
REQ-022 Glyphs SHALL be: blank 7'h7F; '-' 7'h3F; 'P' 7'h0C; 1 7'h79; 2 7'h24; 3 7'h30; 4 7'h19; 5 7'h12; 6 7'h02; 7 7'h78; 8 7'h00; 9 7'h10.

Reset
REQ-023 While reset is high, the block SHALL set: state = TURN, winner = 0, blink counter = 0, blink phase = ON, all HEX = 7'h7F; a reset asserted mid-WIN or mid-DRAW behaves identically.

Configuration
REQ-024 Macro PLAYER_STATUS_BLINK_EN defined: in WIN, the digits alternate between the REQ-018 glyphs (phase ON) and blank (phase OFF).
REQ-025 Blink timing: the phase toggles each time the counter wraps from BLINK_HALF-1 to 0; counter and phase are cleared to 0/ON on the WIN entry cycle; the counter is held at 0 outside WIN.
REQ-026 Macro PLAYER_STATUS_BLINK_EN undefined: the WIN display is steady, and no blink counter or phase register is synthesised.

Structure
REQ-027 A shared package player_status_pkg SHALL hold the state enum, glyph constants, and the digit-to-glyph function.
REQ-028 The sub-module blink_timer SHALL hold the counter and phase, with ports clk, reset, clear, enable, and phase; it is instantiated only under PLAYER_STATUS_BLINK_EN.
REQ-029 Counter width SHALL be clog2(BLINK_HALF); no arithmetic may overflow at BLINK_HALF-1.

Verification
Bench parameters: NUM_PLAYERS=2, NUM_HEX=2, BLINK_HALF=4.
REQ-030 Reset then curPlayer=0 -> one cycle after reset deasserts, HEX[0]=7'h79, HEX[1]=7'h0C, state_o=0.
REQ-031 curPlayer=1 then win pulse, then curPlayer=0 -> HEX[0] stays 7'h24, state_o=1.
REQ-032 win and draw in the same cycle -> state_o=1; a following draw pulse has no effect.
REQ-033 Blink enabled, in WIN -> HEX[0] is 7'h24 for 4 cycles, 7'h7F for 4 cycles, and repeats; blink disabled -> constant 7'h24.
REQ-034 draw pulse -> both digits 7'h3F; new_game -> TURN glyphs return after one cycle; reset asserted mid-DRAW -> 7'h7F on both digits.
REQ-035 NUM_PLAYERS=3, curPlayer=3 -> HEX[0]=7'h3F.
